clk_1mhz_monitor: RTL and testbench

//  Receive-side checker for the divided 1 MHz clock. Samples CLK_1MHZ_IN in the
//  CLK_26MHZ_IN domain and measures every period in 26 MHz cycles. Declares

---
 rtl/clk_1mhz_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_clk_1mhz_monitor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_1mhz_monitor.sv
// rtl/clk_1mhz_monitor.sv - period/lock/fault monitor for the divided 1 MHz clock
//
// Purpose: samples CLK_1MHZ_IN in the CLK_26MHZ_IN domain, measures each
// period in system cycles, declares LOCKED after LOCK_COUNT consecutive
// in-tolerance periods and enters a sticky FAULT on a bad period or a
// missing edge while locked.
//
// Optional feature macro: CLK_MON_DUTY_EN (adds DUTY_ERR and high-time check).
//
// Ports:
//   CLK_26MHZ_IN  in   1      system clock
//   RESET_N       in   1      asynchronous active-low reset
//   CLK_1MHZ_IN   in   1      clock under test, asynchronous
//   CLEAR         in   1      leave FAULT and re-acquire (ignored elsewhere)
//   PERIOD_OUT    out  CNT_W  last measured period in system cycles
//   PERIOD_VALID  out  1      one-cycle pulse when PERIOD_OUT updates
//   LOCKED        out  1      high in LOCKED state
//   FAULT         out  1      high in FAULT state
//   FAULT_COUNT   out  8      saturating count of LOCKED->FAULT transitions
//   DUTY_ERR      out  1      (CLK_MON_DUTY_EN only) bad high-time pulse

module clk_1mhz_monitor #(
  parameter int NOMINAL    = 26,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 8
) (
  input  logic             CLK_26MHZ_IN,
  input  logic             RESET_N,
  input  logic             CLK_1MHZ_IN,
  input  logic             CLEAR,
  output logic [CNT_W-1:0] PERIOD_OUT,
  output logic             PERIOD_VALID,
  output logic             LOCKED,
  output logic             FAULT,
  output logic [7:0]       FAULT_COUNT
`ifdef CLK_MON_DUTY_EN
  ,
  output logic             DUTY_ERR
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] PER_LO    = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0] PER_HI    = CNT_W'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam int               GOOD_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [7:0]        fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  period_q;
  logic              pvalid_q;
  logic [2:0]        sync_q;

  logic rise_p;
  logic timeout_p;
  logic period_good;
  logic clear_win;
  logic measure;
  logic duty_bad;

  // [0],[1] form the synchroniser; [2] is the edge-detect history flop.
  always_ff @(posedge CLK_26MHZ_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], CLK_1MHZ_IN};
    end
  end

  assign rise_p = sync_q[1] & ~sync_q[2];

  // cnt holds the number of cycles since the last rise_p (inclusive), so at
  // the next rise_p it equals the period exactly.
  always_comb begin
    cnt_d = cnt_q;
    if (rise_p) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign period_good = (cnt_q >= PER_LO) && (cnt_q <= PER_HI);
  // cnt only passes through TIMEOUT once per gap, so this fires once.
  assign timeout_p   = ~rise_p && (cnt_q == TIMEOUT_C);
  assign clear_win   = CLEAR && (state_q == ST_FAULT);
  // The first edge after IDLE only starts the measurement; CLEAR in FAULT
  // suppresses the edge it coincides with.
  assign measure     = rise_p && (state_q != ST_IDLE) && !clear_win;

`ifdef CLK_MON_DUTY_EN
  localparam logic [CNT_W-1:0] DUTY_LO = CNT_W'(NOMINAL / 2 - TOL - 1);
  localparam logic [CNT_W-1:0] DUTY_HI = CNT_W'(NOMINAL / 2 + TOL + 1);

  logic [CNT_W-1:0] hcnt_q;
  logic             duty_err_q;
  logic             fall_p;

  assign fall_p = ~sync_q[1] & sync_q[2];

  // Same latency on both edges, so hcnt at fall_p is the exact high time.
  always_ff @(posedge CLK_26MHZ_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      hcnt_q     <= '0;
      duty_err_q <= 1'b0;
    end else begin
      if (rise_p) begin
        hcnt_q <= CNT_W'(1);
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_q <= hcnt_q + 1'b1;
      end
      duty_err_q <= fall_p && (state_q != ST_IDLE) &&
                    ((hcnt_q < DUTY_LO) || (hcnt_q > DUTY_HI));
    end
  end

  assign duty_bad = duty_err_q;
  assign DUTY_ERR = duty_err_q;
`else
  assign duty_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rise_p) begin
          state_d = ST_CHECK;
          good_d  = '0;
        end
      end
      ST_CHECK: begin
        if (rise_p) begin
          if (period_good) begin
            if (good_q == GOOD_LAST) begin
              state_d = ST_LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end else if (timeout_p) begin
          good_d = '0;
        end
      end
      ST_LOCKED: begin
        if ((rise_p && !period_good) || timeout_p || duty_bad) begin
          state_d = ST_FAULT;
          if (fcnt_q != 8'hFF) begin
            fcnt_d = fcnt_q + 8'd1;
          end
        end
      end
      ST_FAULT: begin
        if (CLEAR) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_26MHZ_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      good_q   <= '0;
      fcnt_q   <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      fcnt_q   <= fcnt_d;
      cnt_q    <= cnt_d;
      pvalid_q <= measure;
      if (measure) begin
        period_q <= cnt_q;
      end
    end
  end

  assign PERIOD_OUT   = period_q;
  assign PERIOD_VALID = pvalid_q;
  assign LOCKED       = (state_q == ST_LOCKED);
  assign FAULT        = (state_q == ST_FAULT);
  assign FAULT_COUNT  = fcnt_q;

endmodule

// File: tb/tb_clk_1mhz_monitor.sv
// tb/tb_clk_1mhz_monitor.sv - self-checking bench for clk_1mhz_monitor

module tb_clk_1mhz_monitor;

  localparam int NOMINAL    = 26;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;
  localparam int TIMEOUT    = 64;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clk1m = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] period_out;
  logic             pvalid;
  logic             locked;
  logic             fault;
  logic [7:0]       fcount;
`ifdef CLK_MON_DUTY_EN
  logic             duty_err;
`endif

  int checks = 0;
  int failures = 0;

  logic       s_v3, s_v4, s_lk, s_f;
  logic [7:0] s_p, s_fc;

  int m_state, m_good, m_fc, m_period, m_valid;

  typedef struct {
    int h; int l; int v; int p; int lk; int f; int fc;
  } vec_t;

  vec_t tab_a[8];
  vec_t tab_b[8];

  clk_1mhz_monitor #(
    .NOMINAL(NOMINAL), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .CLK_26MHZ_IN(clk),
    .RESET_N(rst_n),
    .CLK_1MHZ_IN(clk1m),
    .CLEAR(clr),
    .PERIOD_OUT(period_out),
    .PERIOD_VALID(pvalid),
    .LOCKED(locked),
    .FAULT(fault),
    .FAULT_COUNT(fcount)
`ifdef CLK_MON_DUTY_EN
    ,
    .DUTY_ERR(duty_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One input period: edge driven at step 0, high for h steps, low for l.
  // Outputs are sampled at steps 3 and 4, after the edge has been processed.
  task automatic run_period(input int h, input int l, input int clr_at);
    for (int i = 0; i < h + l; i++) begin
      @(negedge clk);
      if (i == 3) begin
        s_v3 = pvalid; s_p = period_out; s_lk = locked; s_f = fault; s_fc = fcount;
      end
      if (i == 4) s_v4 = pvalid;
      clr   = (i == clr_at);
      clk1m = (i < h);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; clk1m = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_state = 0; m_good = 0; m_fc = 0; m_period = 0; m_valid = 0;
  endtask

  task automatic check_row(input string tag, input vec_t r);
    run_period(r.h, r.l, -1);
    chk({tag, ".valid"}, 32'(s_v3), r.v);
    chk({tag, ".pulse"}, 32'(s_v4), 0);
    chk({tag, ".period"}, 32'(s_p), r.p);
    chk({tag, ".locked"}, 32'(s_lk), r.lk);
    chk({tag, ".fault"}, 32'(s_f), r.f);
    chk({tag, ".fcount"}, 32'(s_fc), r.fc);
  endtask

  // Reference model: one call per rising edge, g = cycles since previous edge.
  task automatic model_bad();
    if (m_state == 1) m_good = 0;
    else if (m_state == 2) begin
      m_state = 3;
      if (m_fc < 255) m_fc++;
    end
  endtask

  task automatic model_edge(input int g);
    bit ok;
    m_valid = 0;
    if (m_state != 0 && g > TIMEOUT) model_bad();
    if (m_state == 0) begin
      m_state = 1; m_good = 0;
    end else begin
      m_valid  = 1;
      m_period = (g > 255) ? 255 : g;
      ok = (g >= NOMINAL - TOL) && (g <= NOMINAL + TOL);
      if (!ok) model_bad();
      else if (m_state == 1) begin
        m_good++;
        if (m_good == LOCK_COUNT) begin m_state = 2; m_good = 0; end
      end
    end
  endtask

  initial begin
    tab_a[0] = '{13, 13, 0,  0, 0, 0, 0};
    tab_a[1] = '{13, 13, 1, 26, 0, 0, 0};
    tab_a[2] = '{13, 13, 1, 26, 0, 0, 0};
    tab_a[3] = '{13, 13, 1, 26, 0, 0, 0};
    tab_a[4] = '{13, 13, 1, 26, 1, 0, 0};
    tab_a[5] = '{15, 15, 1, 26, 1, 0, 0};
    tab_a[6] = '{13, 13, 1, 30, 0, 1, 1};
    tab_a[7] = '{13, 13, 1, 26, 0, 1, 1};

    tab_b[0] = '{13, 14, 0, 26, 0, 0, 1};
    tab_b[1] = '{13, 12, 1, 27, 0, 0, 1};
    tab_b[2] = '{13, 15, 1, 25, 0, 0, 1};
    tab_b[3] = '{13, 13, 1, 28, 0, 0, 1};
    tab_b[4] = '{13, 13, 1, 26, 0, 0, 1};
    tab_b[5] = '{13, 13, 1, 26, 0, 0, 1};
    tab_b[6] = '{13, 13, 1, 26, 0, 0, 1};
    tab_b[7] = '{13, 13, 1, 26, 1, 0, 1};

    do_reset();
    @(negedge clk);
    chk("rst.period", 32'(period_out), 0);
    chk("rst.valid", 32'(pvalid), 0);
    chk("rst.locked", 32'(locked), 0);
    chk("rst.fault", 32'(fault), 0);
    chk("rst.fcount", 32'(fcount), 0);

    // Acquire, lock, then a 30-cycle period faults.
    for (int n = 0; n < 8; n++) check_row($sformatf("A%0d", n), tab_a[n]);

    run_period(0, 10, 4);
    chk("clr.fault", 32'(fault), 0);
    chk("clr.fcount", 32'(fcount), 1);

    // Re-acquire with 27/25 accepted and 28 restarting the good count.
    for (int n = 0; n < 8; n++) check_row($sformatf("B%0d", n), tab_b[n]);

    // Missing clock while locked: fault exactly when cnt reaches TIMEOUT.
    for (int i = 26; i < 70; i++) begin
      @(negedge clk);
      if (i == 66) begin
        chk("to.before_fault", 32'(fault), 0);
        chk("to.before_locked", 32'(locked), 1);
      end
      if (i == 67) begin
        chk("to.fault", 32'(fault), 1);
        chk("to.locked", 32'(locked), 0);
        chk("to.fcount", 32'(fcount), 2);
      end
    end

    // CLEAR in the same cycle as rise_p: CLEAR wins, edge not counted.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i == 3) begin
        chk("clrrise.fault", 32'(fault), 0);
        chk("clrrise.locked", 32'(locked), 0);
        chk("clrrise.valid", 32'(pvalid), 0);
        chk("clrrise.fcount", 32'(fcount), 2);
      end
      clr   = (i == 2);
      clk1m = (i < 13);
    end
    for (int n = 0; n < 5; n++) begin
      run_period(13, 13, -1);
      chk($sformatf("relock%0d.locked", n), 32'(s_lk), (n == 4) ? 1 : 0);
    end

    // Third fault, clear, lock again, then asynchronous reset.
    run_period(15, 15, -1);
    run_period(13, 13, -1);
    chk("f3.fault", 32'(s_f), 1);
    chk("f3.fcount", 32'(s_fc), 3);
    run_period(13, 13, 10);
    for (int n = 0; n < 5; n++) run_period(13, 13, -1);
    chk("f3.relocked", 32'(s_lk), 1);
    chk("f3.fcount_kept", 32'(s_fc), 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.period", 32'(period_out), 0);
    chk("arst.valid", 32'(pvalid), 0);
    chk("arst.locked", 32'(locked), 0);
    chk("arst.fault", 32'(fault), 0);
    chk("arst.fcount", 32'(fcount), 0);

    // Randomised periods and CLEARs against the reference model.
    do_reset();
    begin
      int prev_len = 0;
      for (int n = 0; n < 150; n++) begin
        int r, g, h, ca;
        r = $urandom_range(0, 19);
        if (r < 12)       g = $urandom_range(NOMINAL - TOL, NOMINAL + TOL);
        else if (r < 14)  g = ($urandom_range(0, 1) == 0) ? NOMINAL - TOL - 1 : NOMINAL + TOL + 1;
        else if (r == 14) g = $urandom_range(6, 40);
        else if (r == 15) g = $urandom_range(TIMEOUT - 1, TIMEOUT + 1);
        else if (r == 16) g = 300;
        else              g = NOMINAL;
        h  = g / 2;
        ca = -1;
        if (g >= 10 && $urandom_range(0, 3) == 0) ca = $urandom_range(5, (g - 1 < 60) ? g - 1 : 60);
        run_period(h, g - h, ca);
        model_edge(prev_len);
        chk($sformatf("R%0d.valid", n), 32'(s_v3), m_valid);
        chk($sformatf("R%0d.pulse", n), 32'(s_v4), 0);
        chk($sformatf("R%0d.period", n), 32'(s_p), m_period);
        chk($sformatf("R%0d.locked", n), 32'(s_lk), (m_state == 2) ? 1 : 0);
        chk($sformatf("R%0d.fault", n), 32'(s_f), (m_state == 3) ? 1 : 0);
        chk($sformatf("R%0d.fcount", n), 32'(s_fc), m_fc);
        if (ca >= 0 && m_state == 3) m_state = 0;
        prev_len = g;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
